led_frame_loader: RTL and testbench



---
 rtl/led_pkg.sv | 19 +
 rtl/led_rx_timeout.sv | 24 ++
 rtl/led_frame_loader.sv | 135 +++++++++++++
 tb/tb_led_frame_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and state type for the LED frame loader.
package led_pkg;

  localparam int DATA_W = 4 * 3;
  localparam int ADD_W  = 4 + 4;

  localparam logic [7:0] HDR_FRAME = 8'hA5;
  localparam logic [7:0] HDR_PIXEL = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    FR_HI,
    FR_LO,
    PX_ADDR,
    PX_HI,
    PX_LO
  } ld_state_e;

endpackage

// File: rtl/led_rx_timeout.sv
// Inter-byte idle counter; expired flags the last allowed idle cycle.
module led_rx_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clear || expired) cnt <= '0;
    else if (enable)      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_frame_loader.sv
// Byte-stream parser that turns frame / single-pixel packets into VRAM writes.
module led_frame_loader
  import led_pkg::*;
#(
  parameter  int COL_N        = 16,
  parameter  int ROW_N        = 16,
  parameter  int BITS_PER_COL = 4,
  parameter  int COLOURS      = 3,
  parameter  int TIMEOUT      = 1000,
  localparam int DW           = BITS_PER_COL * COLOURS,
  localparam int AW           = $clog2(COL_N) + $clog2(ROW_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] wr_add,
  output logic          wr_en,
  output logic          frame_done,
  output logic          err,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_PIX = AW'(COL_N * ROW_N - 1);

  ld_state_e     state, state_n;
  logic [AW-1:0] pix_q, pix_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [3:0]    c2_q, c2_n;
  logic [DW-1:0] wr_data_n;
  logic [AW-1:0] wr_add_n;
  logic          wr_en_n, frame_done_n, err_n;
  logic          accept, expired;

  assign rx_ready = !rst;
  assign accept   = rx_valid && rx_ready;
  assign busy     = (state != IDLE);

  led_rx_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .clear   (rst || accept || !busy),
    .enable  (busy),
    .expired (expired)
  );

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    pix_n        = pix_q;
    addr_n       = addr_q;
    c2_n         = c2_q;
    wr_data_n    = wr_data;
    wr_add_n     = wr_add;
    wr_en_n      = 1'b0;
    frame_done_n = 1'b0;
    err_n        = 1'b0;

    if (expired && !accept) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (accept) begin
      unique case (state)
        IDLE: begin
          if (rx_data == HDR_FRAME) begin
            state_n = FR_HI;
            pix_n   = '0;
          end else if (rx_data == HDR_PIXEL) begin
            state_n = PX_ADDR;
          end
        end
        FR_HI, PX_HI: begin
          if (rx_data[7:4] != 4'h0) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            c2_n    = rx_data[3:0];
            state_n = (state == FR_HI) ? FR_LO : PX_LO;
          end
        end
        FR_LO: begin
          wr_en_n   = 1'b1;
          wr_data_n = DW'({c2_q, rx_data});
          wr_add_n  = pix_q;
          if (pix_q == LAST_PIX) begin
            frame_done_n = 1'b1;
            state_n      = IDLE;
          end else begin
            pix_n   = pix_q + 1'b1;
            state_n = FR_HI;
          end
        end
        PX_ADDR: begin
          addr_n  = AW'(rx_data);
          state_n = PX_HI;
        end
        PX_LO: begin
          wr_en_n   = 1'b1;
          wr_data_n = DW'({c2_q, rx_data});
          wr_add_n  = addr_q;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: all registers here are plain flops (no RAM), so each one is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_q      <= '0;
      addr_q     <= '0;
      c2_q       <= '0;
      wr_data    <= '0;
      wr_add     <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      pix_q      <= pix_n;
      addr_q     <= addr_n;
      c2_q       <= c2_n;
      wr_data    <= wr_data_n;
      wr_add     <= wr_add_n;
      wr_en      <= wr_en_n;
      frame_done <= frame_done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized byte stream scored against a packet-level model.
module tb_led_frame_loader;
  import led_pkg::*;

  localparam int TO   = 8;
  localparam int NPIX = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] wr_data;
  logic [ADD_W-1:0]  wr_add;
  logic              wr_en, frame_done, err, busy;

  led_frame_loader #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_data    (wr_data),
    .wr_add     (wr_add),
    .wr_en      (wr_en),
    .frame_done (frame_done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t04;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  add;
    logic [11:0] data;
    bit          fd;
    int          cyc;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en || frame_done) act_q.push_back(ev_t'{1'b0, wr_add, wr_data, frame_done, cyc});
    if (err)                 act_q.push_back(ev_t'{1'b1, 8'h00, 12'h000, 1'b0, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packet-level reference model: position within the current packet decides
  // the meaning of each byte; an idle gap of TO or more mid-packet aborts it.
  int         m_len = 0;
  bit         m_frame;
  logic [3:0] m_c2;
  logic [7:0] m_addr;

  task automatic push_wr(input int a, input logic [11:0] d, input bit fd);
    exp_q.push_back(ev_t'{1'b0, 8'(a), d, fd, 0});
  endtask

  task automatic push_err();
    exp_q.push_back(ev_t'{1'b1, 8'h00, 12'h000, 1'b0, 0});
  endtask

  task automatic model_byte(input logic [7:0] b, input int gap);
    int pos, k;
    if (m_len > 0 && gap >= TO) begin
      push_err();
      m_len = 0;
    end
    if (m_len == 0) begin
      if (b == HDR_FRAME) begin m_frame = 1'b1; m_len = 1; end
      else if (b == HDR_PIXEL) begin m_frame = 1'b0; m_len = 1; end
      return;
    end
    pos = m_len;
    m_len++;
    if ((m_frame && pos % 2 == 1) || (!m_frame && pos == 2)) begin
      if (b[7:4] != 4'h0) begin push_err(); m_len = 0; end
      else m_c2 = b[3:0];
    end else if (m_frame) begin
      k = pos / 2 - 1;
      push_wr(k, {m_c2, b}, k == NPIX - 1);
      if (k == NPIX - 1) m_len = 0;
    end else if (pos == 1) begin
      m_addr = b;
    end else begin
      push_wr(m_addr, {m_c2, b}, 1'b0);
      m_len = 0;
    end
  endtask

  task automatic model_end(input int gap);
    if (m_len > 0 && gap >= TO) begin
      push_err();
      m_len = 0;
    end
  endtask

  task automatic drive(input logic [7:0] b, input int gap);
    idle(gap);
    send_byte(b);
    model_byte(b, gap);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    idle(2);
    rst   = 1'b0;
    m_len = 0;
  endtask

  task automatic compare_events(input string tag);
    int n;
    check($sformatf("%s.count", tag), act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].err", tag, i), act_q[i].is_err, exp_q[i].is_err);
      check($sformatf("%s[%0d].add", tag, i), act_q[i].add, exp_q[i].add);
      check($sformatf("%s[%0d].data", tag, i), act_q[i].data, exp_q[i].data);
      check($sformatf("%s[%0d].fd", tag, i), act_q[i].fd, exp_q[i].fd);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    int          wr;
    logic [7:0]  add;
    logic [11:0] data;
    int          errs;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int wr_cnt, err_cnt;
    logic [7:0]  last_add;
    logic [11:0] last_data;
    logic [3:0]  nib;

    tbl[0] = vec_t'{32'h00FF1200, 3, 0, 8'h00, 12'h000, 0};
    tbl[1] = vec_t'{32'hA5100000, 2, 0, 8'h00, 12'h000, 1};
    tbl[2] = vec_t'{32'h5A370F21, 4, 1, 8'h37, 12'hF21, 0};
    tbl[3] = vec_t'{32'h5A000000, 4, 1, 8'h00, 12'h000, 0};
    tbl[4] = vec_t'{32'h5AFF0ABC, 4, 1, 8'hFF, 12'hABC, 0};
    tbl[5] = vec_t'{32'h5A12F000, 3, 0, 8'h00, 12'h000, 1};
    tbl[6] = vec_t'{32'h5AA50102, 4, 1, 8'hA5, 12'h102, 0};
    tbl[7] = vec_t'{32'hA5A50000, 2, 0, 8'h00, 12'h000, 1};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("rst.rx_ready", rx_ready, 0);
    check("rst.wr_en", wr_en, 0);
    check("rst.frame_done", frame_done, 0);
    check("rst.err", err, 0);
    check("rst.busy", busy, 0);
    check("rst.wr_data", wr_data, 0);
    check("rst.wr_add", wr_add, 0);
    rst = 1'b0;
    #1;
    check("run.rx_ready", rx_ready, 1);
    act_q.delete();

    // Directed vector table, one short packet (or garbage) per entry.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < tbl[i].n; j++) send_byte(tbl[i].bytes[31-8*j -: 8]);
      idle(3);
      wr_cnt = 0; err_cnt = 0; last_add = '0; last_data = '0;
      foreach (act_q[e]) begin
        if (act_q[e].is_err) err_cnt++;
        else begin wr_cnt++; last_add = act_q[e].add; last_data = act_q[e].data; end
      end
      check($sformatf("vec%0d.writes", i), wr_cnt, tbl[i].wr);
      check($sformatf("vec%0d.errs", i), err_cnt, tbl[i].errs);
      check($sformatf("vec%0d.busy", i), busy, 0);
      if (tbl[i].wr > 0) begin
        check($sformatf("vec%0d.add", i), last_add, tbl[i].add);
        check($sformatf("vec%0d.data", i), last_data, tbl[i].data);
      end
      act_q.delete();
    end

    // Pixel write: busy drops in the same cycle the write appears.
    send_byte(8'h5A);
    send_byte(8'h37);
    send_byte(8'h0F);
    check("px.busy_mid", busy, 1);
    send_byte(8'h21);
    check("px.wr_en", wr_en, 1);
    check("px.busy_after", busy, 0);
    check("px.wr_add", wr_add, 8'h37);
    check("px.wr_data", wr_data, 12'hF21);
    idle(2);
    act_q.delete();

    // Full frame, pixel k = k % 16 in every colour.
    send_byte(HDR_FRAME);
    for (int k = 0; k < NPIX; k++) begin
      nib = 4'(k % 16);
      send_byte({4'h0, nib});
      send_byte({nib, nib});
      exp_q.push_back(ev_t'{1'b0, 8'(k), {nib, nib, nib}, k == NPIX - 1, 0});
    end
    idle(3);
    compare_events("frame");
    check("frame.busy", busy, 0);

    // Timeout: err lands exactly TO cycles after the last accepted byte.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h23); send_byte(8'h04);
    t04 = cyc;
    idle(12);
    foreach (act_q[e]) if (act_q[e].is_err) check("timeout.latency", act_q[e].cyc - t04, TO);
    push_wr(0, 12'h123, 1'b0);
    push_err();
    compare_events("timeout");

    // A byte on the last allowed cycle is taken normally.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h23); send_byte(8'h04);
    idle(TO - 1);
    send_byte(8'h05);
    idle(3);
    push_wr(0, 12'h123, 1'b0);
    push_wr(1, 12'h405, 1'b0);
    compare_events("no_timeout");
    do_reset();
    idle(TO + 4);
    compare_events("no_timeout.after_rst");

    // Reset in the middle of pixel 100, then a fresh frame from address 0.
    drive(HDR_FRAME, 0);
    for (int k = 0; k < 100; k++) begin
      drive(8'($urandom_range(0, 15)), 0);
      drive(8'($urandom), 0);
    end
    drive(8'h0C, 0);
    do_reset();
    idle(TO + 4);
    compare_events("mid_rst");
    drive(HDR_FRAME, 0);
    drive(8'h07, 0);
    drive(8'h89, 0);
    idle(2);
    compare_events("restart");
    do_reset();

    // Randomized stream with gaps straddling the timeout boundary.
    for (int i = 0; i < 600; i++) begin
      int r, gap, c;
      logic [7:0] b;
      r   = $urandom_range(0, 19);
      gap = (r < 12) ? 0 : (r < 15) ? $urandom_range(1, 3) : $urandom_range(TO - 2, TO + 1);
      c   = $urandom_range(0, 9);
      b   = (c < 2) ? HDR_FRAME : (c == 2) ? HDR_PIXEL :
            (c < 8) ? {4'h0, 4'($urandom)} : 8'($urandom);
      drive(b, gap);
    end
    idle(TO + 4);
    model_end(TO + 4);
    compare_events("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
